// File: rtl/wb_timer.sv
// ---------------------------------------------------------------------------
// wb_timer -- Wishbone B4 pipelined-slave machine timer (mtime / mtimecmp).
//
// A prescaler divides clk by PRESCALE_DIV to advance a 64-bit mtime. The
// registered irq_timer is high while the timer is enabled and
// mtime >= mtimecmp (unsigned).
//
// Register map (byte offset, decoded on wb_adr[4:2]):
//   0x00 MTIME_LO     read also latches mtime[63:32] into shadow_hi
//   0x04 MTIME_HI     reads return shadow_hi; writes also update shadow_hi
//   0x08 MTIMECMP_LO
//   0x0C MTIMECMP_HI
//   0x10 CTRL         bit0 = EN, other bits read 0
//   0x14..0x1C        unmapped
//
// Optional build macro WB_TIMER_ERR_EN:
//   defined   - unmapped accesses answer with wb_err instead of wb_ack.
//   undefined - unmapped accesses are acked; reads give 0, writes are
//               ignored; wb_err is tied to 0.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   wb_cyc     bus cycle in progress
//   wb_stb     request strobe
//   wb_we      write enable
//   wb_adr     byte address (only [4:2] decoded)
//   wb_sel     byte lane enables for writes
//   wb_dat_m   write data from the master
//   wb_ack     one-cycle acknowledge, one cycle after acceptance
//   wb_err     one-cycle error response (WB_TIMER_ERR_EN only)
//   wb_stall   always 0
//   wb_dat_s   read data, valid only in the ack cycle, 0 otherwise
//   irq_timer  level timer interrupt to the core
// ---------------------------------------------------------------------------
module wb_timer #(
    parameter int unsigned PRESCALE_DIV = 100,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [31:0] wb_adr,
    input  logic [3:0]  wb_sel,
    input  logic [31:0] wb_dat_m,
    output logic        wb_ack,
    output logic        wb_err,
    output logic        wb_stall,
    output logic [31:0] wb_dat_s,
    output logic        irq_timer
);

    localparam logic [15:0] PRESCALE_LAST = 16'(PRESCALE_DIV - 1);

    localparam logic [2:0] OFF_MTIME_LO = 3'd0;
    localparam logic [2:0] OFF_MTIME_HI = 3'd1;
    localparam logic [2:0] OFF_CMP_LO   = 3'd2;
    localparam logic [2:0] OFF_CMP_HI   = 3'd3;
    localparam logic [2:0] OFF_CTRL     = 3'd4;

    logic [63:0] mtime;
    logic [63:0] mtime_nxt;
    logic [63:0] mtimecmp;
    logic [15:0] prescale_cnt;
    logic        en;
    logic [31:0] shadow_hi;

    logic        req;
    logic        wr;
    logic        rd;
    logic [2:0]  off;
    logic [31:0] byte_mask;
    logic        sel_any;
    logic        tick;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic [31:0] mtime_lo_wr;
    logic [31:0] mtime_hi_wr;
    logic [31:0] rd_data;
    logic        ack_q;
    logic [31:0] dat_q;
    logic        unused_adr;

    // Handshake: a request is valid when wb_cyc & wb_stb; the slave is
    // always ready (wb_stall = 0), so every valid cycle is an accepted
    // request and gets exactly one response (ack or err) in the next cycle,
    // even if wb_cyc drops in that next cycle.
    assign req = wb_cyc & wb_stb;
    assign wr  = req & wb_we;
    assign rd  = req & ~wb_we;
    assign off = wb_adr[4:2];

    assign unused_adr = ^{wb_adr[31:5], wb_adr[1:0]};

    assign byte_mask = {{8{wb_sel[3]}}, {8{wb_sel[2]}},
                        {8{wb_sel[1]}}, {8{wb_sel[0]}}};
    assign sel_any   = |wb_sel;

    assign tick = en && (prescale_cnt == PRESCALE_LAST);

    // sel = 0 writes nothing, so it must not suppress a pending increment.
    assign wr_mtime_lo = wr && sel_any && (off == OFF_MTIME_LO);
    assign wr_mtime_hi = wr && sel_any && (off == OFF_MTIME_HI);

    assign mtime_lo_wr = (mtime[31:0]  & ~byte_mask) | (wb_dat_m & byte_mask);
    assign mtime_hi_wr = (mtime[63:32] & ~byte_mask) | (wb_dat_m & byte_mask);

    // A bus write to either half of mtime overrides that cycle's increment:
    // the other half keeps its pre-increment value and no carry is applied.
    always_comb begin
        mtime_nxt = tick ? (mtime + 64'd1) : mtime;
        if (wr_mtime_lo) begin
            mtime_nxt = {mtime[63:32], mtime_lo_wr};
        end else if (wr_mtime_hi) begin
            mtime_nxt = {mtime_hi_wr, mtime[31:0]};
        end
    end

    always_comb begin
        rd_data = 32'd0;
        case (off)
            OFF_MTIME_LO: rd_data = mtime[31:0];
            OFF_MTIME_HI: rd_data = shadow_hi;
            OFF_CMP_LO:   rd_data = mtimecmp[31:0];
            OFF_CMP_HI:   rd_data = mtimecmp[63:32];
            OFF_CTRL:     rd_data = {31'd0, en};
            default:      rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mtime        <= 64'd0;
            mtimecmp     <= MTIMECMP_RST;
            prescale_cnt <= 16'd0;
            en           <= 1'b1;
            shadow_hi    <= 32'd0;
            irq_timer    <= 1'b0;
            ack_q        <= 1'b0;
            dat_q        <= 32'd0;
        end else begin
            if (en) begin
                prescale_cnt <= tick ? 16'd0 : (prescale_cnt + 16'd1);
            end
            mtime <= mtime_nxt;

            if (wr && (off == OFF_CMP_LO)) begin
                mtimecmp[31:0] <= (mtimecmp[31:0] & ~byte_mask) | (wb_dat_m & byte_mask);
            end
            if (wr && (off == OFF_CMP_HI)) begin
                mtimecmp[63:32] <= (mtimecmp[63:32] & ~byte_mask) | (wb_dat_m & byte_mask);
            end
            if (wr && (off == OFF_CTRL) && wb_sel[0]) begin
                en <= wb_dat_m[0];
            end

            // LO read snapshots the high half so a following HI read pairs
            // with the LO value just returned, even across a carry.
            if (rd && (off == OFF_MTIME_LO)) begin
                shadow_hi <= mtime[63:32];
            end else if (wr_mtime_hi) begin
                shadow_hi <= mtime_hi_wr;
            end

            // Compare uses the current registers, giving one cycle latency.
            irq_timer <= en && (mtime >= mtimecmp);

            dat_q <= rd ? rd_data : 32'd0;
`ifdef WB_TIMER_ERR_EN
            ack_q <= req && (off <= OFF_CTRL);
`else
            ack_q <= req;
`endif
        end
    end

`ifdef WB_TIMER_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= req && (off > OFF_CTRL);
        end
    end

    assign wb_err = err_q;
`else
    assign wb_err = 1'b0;
`endif

    assign wb_ack   = ack_q;
    assign wb_dat_s = dat_q;
    assign wb_stall = 1'b0;

endmodule
